// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/short/long/repeat
// events, timing the hold duration against a free-running tick prescaler.
module button_event_decoder #(
    parameter int unsigned TICK_CYCLES  = 100000,
    parameter int unsigned LONG_TICKS   = 1000,
    parameter int unsigned REPEAT_TICKS = 200,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic button_level_i,
    output logic press_o,
    output logic release_o,
    output logic short_press_o,
    output logic long_press_o,
    output logic repeat_o,
    output logic held_o
);
    localparam int unsigned PW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    localparam logic [CNT_WIDTH-1:0] LONG_MAX = CNT_WIDTH'(LONG_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] REP_MAX =
        (REPEAT_TICKS == 0) ? '0 : CNT_WIDTH'(REPEAT_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic REPEAT_EN = (REPEAT_TICKS != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   level_q;
    logic [PW-1:0]          presc_q;
    logic [PW-1:0]          presc_d;
    logic [CNT_WIDTH-1:0]   hold_cnt_q;
    logic [CNT_WIDTH-1:0]   rep_cnt_q;
    logic                   rise;
    logic                   fall;
    logic                   tick;

    assign rise = button_level_i & ~level_q;
    assign fall = ~button_level_i & level_q;
    assign tick = (presc_q == PRESC_MAX);

    always_comb begin
        presc_d = presc_q + PRESC_ONE;
        if (tick) begin
            presc_d = '0;
        end
    end

    // level_q resets high so a button held through reset never looks like a fresh press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= 1'b1;
            presc_q <= '0;
        end else begin
            level_q <= button_level_i;
            presc_q <= presc_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            rep_cnt_q     <= '0;
            press_o       <= 1'b0;
            release_o     <= 1'b0;
            short_press_o <= 1'b0;
            long_press_o  <= 1'b0;
            repeat_o      <= 1'b0;
            held_o        <= 1'b0;
        end else begin
            press_o       <= 1'b0;
            release_o     <= 1'b0;
            short_press_o <= 1'b0;
            long_press_o  <= 1'b0;
            repeat_o      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q    <= PRESSED;
                        hold_cnt_q <= '0;
                        press_o    <= 1'b1;
                        held_o     <= 1'b1;
                    end
                end
                // A release always wins over a tick landing in the same cycle.
                PRESSED: begin
                    if (fall) begin
                        state_q       <= IDLE;
                        release_o     <= 1'b1;
                        short_press_o <= 1'b1;
                        held_o        <= 1'b0;
                    end else if (tick) begin
                        if (hold_cnt_q == LONG_MAX) begin
                            state_q      <= LONG;
                            long_press_o <= 1'b1;
                            rep_cnt_q    <= '0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + CNT_ONE;
                        end
                    end
                end
                LONG: begin
                    if (fall) begin
                        state_q   <= IDLE;
                        release_o <= 1'b1;
                        held_o    <= 1'b0;
                    end else if (tick && REPEAT_EN) begin
                        if (rep_cnt_q == REP_MAX) begin
                            repeat_o  <= 1'b1;
                            rep_cnt_q <= '0;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    held_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_button_event_decoder.sv
// Directed and random checks of button_event_decoder with a 4-cycle tick,
// 3-tick long threshold and 2-tick repeat, plus a repeat-disabled instance.
module tb_button_event_decoder;
    logic clk;
    logic rst;
    logic button;
    logic button2;
    logic press, rel, shrt, lng, rpt, held;
    logic press2, rel2, shrt2, lng2, rpt2, held2;
    logic [5:0] obs;
    logic [5:0] obs2;
    int n_cmp;
    int n_fail;
    int edge_no;

    // Bit order: press, release, short_press, long_press, repeat, held
    assign obs  = {press, rel, shrt, lng, rpt, held};
    assign obs2 = {press2, rel2, shrt2, lng2, rpt2, held2};

    button_event_decoder #(
        .TICK_CYCLES(4), .LONG_TICKS(3), .REPEAT_TICKS(2), .CNT_WIDTH(16)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .button_level_i(button),
        .press_o(press), .release_o(rel), .short_press_o(shrt),
        .long_press_o(lng), .repeat_o(rpt), .held_o(held)
    );

    button_event_decoder #(
        .TICK_CYCLES(4), .LONG_TICKS(3), .REPEAT_TICKS(0), .CNT_WIDTH(16)
    ) u_norep (
        .clk_i(clk), .rst_i(rst), .button_level_i(button2),
        .press_o(press2), .release_o(rel2), .short_press_o(shrt2),
        .long_press_o(lng2), .repeat_o(rpt2), .held_o(held2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        edge_no++;
    endtask

    task automatic goto_edge(input int n);
        while (edge_no < n) step();
    endtask

    task automatic do_reset(input logic lvl);
        button  = lvl;
        button2 = lvl;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        edge_no = 0;
    endtask

    task automatic test_reset();
        button  = 1'b0;
        button2 = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 6'b0 || obs2 !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %b/%b expected 000000/000000", obs, obs2);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        edge_no = 0;
        for (int n = 1; n <= 3; n++) begin
            step();
            n_cmp++;
            if (obs !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_idle edge=%0d: got %b expected 000000", n, obs);
            end
        end
    endtask

    task automatic test_short_press();
        logic [5:0] exp_v;
        goto_edge(19);
        for (int n = 20; n <= 27; n++) begin
            button = (n >= 20 && n <= 23);
            step();
            exp_v = 6'b0;
            if (n == 20) exp_v[5] = 1'b1;
            if (n == 24) exp_v[4:3] = 2'b11;
            if (n >= 20 && n <= 23) exp_v[0] = 1'b1;
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL short_press edge=%0d: got %b expected %b", n, obs, exp_v);
            end
        end
    endtask

    task automatic test_long_press();
        logic [5:0] exp_v;
        goto_edge(28);
        for (int n = 29; n <= 71; n++) begin
            button = (n <= 68);
            step();
            exp_v = 6'b0;
            if (n == 29) exp_v[5] = 1'b1;
            if (n == 69) exp_v[4] = 1'b1;
            if (n == 40) exp_v[2] = 1'b1;
            if (n == 48 || n == 56 || n == 64) exp_v[1] = 1'b1;
            if (n <= 68) exp_v[0] = 1'b1;
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL long_repeat edge=%0d: got %b expected %b", n, obs, exp_v);
            end
        end
    endtask

    task automatic test_fall_at_threshold();
        logic [5:0] exp_v;
        goto_edge(72);
        for (int n = 73; n <= 90; n++) begin
            button = (n <= 83);
            step();
            exp_v = 6'b0;
            if (n == 73) exp_v[5] = 1'b1;
            if (n == 84) exp_v[4:3] = 2'b11;
            if (n <= 83) exp_v[0] = 1'b1;
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL fall_at_threshold edge=%0d: got %b expected %b", n, obs, exp_v);
            end
        end
    endtask

    task automatic test_held_through_reset();
        logic [5:0] exp_v;
        do_reset(1'b1);
        for (int n = 1; n <= 42; n++) begin
            button = (n <= 30) || (n == 36) || (n == 37);
            step();
            exp_v = 6'b0;
            if (n == 36) exp_v[5] = 1'b1;
            if (n == 38) exp_v[4:3] = 2'b11;
            if (n == 36 || n == 37) exp_v[0] = 1'b1;
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL held_through_reset edge=%0d: got %b expected %b", n, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_in_long();
        logic [5:0] exp_v;
        do_reset(1'b0);
        goto_edge(4);
        for (int n = 5; n <= 18; n++) begin
            button = 1'b1;
            step();
            exp_v = 6'b000001;
            if (n == 5) exp_v[5] = 1'b1;
            if (n == 16) exp_v[2] = 1'b1;
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL pre_reset_long edge=%0d: got %b expected %b", n, obs, exp_v);
            end
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_in_long_async: got %b expected 000000", obs);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        edge_no = 0;
        for (int n = 1; n <= 12; n++) begin
            button = (n <= 3);
            step();
            n_cmp++;
            if (obs !== 6'b0) begin
                n_fail++;
                $display("FAIL after_reset_in_long edge=%0d: got %b expected 000000", n, obs);
            end
        end
    endtask

    task automatic test_no_repeat();
        logic [5:0] exp_v;
        int rpt_seen;
        rpt_seen = 0;
        do_reset(1'b0);
        goto_edge(4);
        for (int n = 5; n <= 110; n++) begin
            button2 = (n <= 105);
            step();
            if (rpt2) rpt_seen++;
            exp_v = 6'b0;
            if (n == 5) exp_v[5] = 1'b1;
            if (n == 16) exp_v[2] = 1'b1;
            if (n == 106) exp_v[4] = 1'b1;
            if (n <= 105) exp_v[0] = 1'b1;
            n_cmp++;
            if (obs2 !== exp_v) begin
                n_fail++;
                $display("FAIL no_repeat edge=%0d: got %b expected %b", n, obs2, exp_v);
            end
        end
        n_cmp++;
        if (rpt_seen != 0) begin
            n_fail++;
            $display("FAIL no_repeat_count: got %0d expected 0", rpt_seen);
        end
    endtask

    task automatic test_random();
        int hi, lo;
        int c_press, c_rel, c_short, c_long;
        c_press = 0; c_rel = 0; c_short = 0; c_long = 0;
        do_reset(1'b0);
        goto_edge(2);
        for (int i = 0; i < 20; i++) begin
            hi = $urandom_range(30, 1);
            lo = $urandom_range(12, 1);
            for (int c = 0; c < hi + lo; c++) begin
                button = (c < hi);
                step();
                c_press += int'(press);
                c_rel   += int'(rel);
                c_short += int'(shrt);
                c_long  += int'(lng);
                n_cmp++;
                if ($countones({press, rel, lng, rpt}) > 1 || (shrt && !rel)) begin
                    n_fail++;
                    $display("FAIL random_onehot iter=%0d: got %b expected at most one event",
                             i, obs);
                end
            end
        end
        button = 1'b0;
        for (int c = 0; c < 4; c++) step();
        n_cmp++;
        if (c_press != 20 || c_rel != 20) begin
            n_fail++;
            $display("FAIL random_counts: got press=%0d release=%0d expected 20/20",
                     c_press, c_rel);
        end
        n_cmp++;
        if (c_short + c_long != 20) begin
            n_fail++;
            $display("FAIL random_short_long: got %0d expected 20", c_short + c_long);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        edge_no = 0;
        rst = 1'b0;
        button = 1'b0;
        button2 = 1'b0;
        #2;
        test_reset();
        test_short_press();
        test_long_press();
        test_fall_at_threshold();
        test_held_through_reset();
        test_reset_in_long();
        test_no_repeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
